// File: rtl/uart_byte_tx.sv
// UART transmitter that drains the capture buffer one byte at a time over a get/ready handshake
// and sends each byte as start, LSB-first data, optional parity and stop bit(s).
module uart_byte_tx #(
    parameter int N         = 8,
    parameter int CLK_DIV   = 434,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic         rdclk,
    input  logic         nreset,
    input  logic         en,
    input  logic         buf_empty,
    input  logic [N-1:0] byte_in,
    input  logic         byte_ready,
    output logic         get,
    output logic         tx,
    output logic         busy
);

    localparam int TW = $clog2(CLK_DIV);
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(N - 1);
    localparam logic          S_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {IDLE, REQ, START, DATA, PARITY_BIT, STOP} state_t;

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [BW-1:0] bit_idx, bit_d;
    logic          stop_idx, stop_d;
    logic [N-1:0]  shift, shift_d;
    logic          par_bit, par_d;
    logic          get_d, tx_d, busy_d;
    logic          bit_end;

    always_ff @(posedge rdclk or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            par_bit  <= 1'b0;
            get      <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            timer    <= timer_d;
            bit_idx  <= bit_d;
            stop_idx <= stop_d;
            shift    <= shift_d;
            par_bit  <= par_d;
            get      <= get_d;
            tx       <= tx_d;
            busy     <= busy_d;
        end
    end

    always_comb begin
        state_d = state;
        timer_d = timer;
        bit_d   = bit_idx;
        stop_d  = stop_idx;
        shift_d = shift;
        par_d   = par_bit;
        get_d   = get;
        tx_d    = tx;
        busy_d  = busy;
        bit_end = (timer == T_LAST);

        // The bit timer free-runs through the frame and wraps on every bit boundary.
        if (state inside {START, DATA, PARITY_BIT, STOP})
            timer_d = bit_end ? '0 : timer + 1'b1;

        case (state)
            IDLE: begin
                if (en && !buf_empty) begin
                    state_d = REQ;
                    get_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            REQ: begin
                // get drops on the capture edge so the buffer hands over exactly one byte.
                if (byte_ready) begin
                    shift_d = byte_in;
                    par_d   = (PARITY == 2) ? ~(^byte_in) : ^byte_in;
                    get_d   = 1'b0;
                    tx_d    = 1'b0;
                    timer_d = '0;
                    state_d = START;
                end else if (buf_empty) begin
                    get_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d    = shift[0];
                    shift_d = shift >> 1;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == B_LAST) begin
                        if (PARITY != 0) begin
                            tx_d    = par_bit;
                            state_d = PARITY_BIT;
                        end else begin
                            tx_d    = 1'b1;
                            stop_d  = 1'b0;
                            state_d = STOP;
                        end
                    end else begin
                        tx_d    = shift[0];
                        shift_d = shift >> 1;
                        bit_d   = bit_idx + 1'b1;
                    end
                end
            end
            PARITY_BIT: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_idx == S_LAST) begin
                        if (en && !buf_empty) begin
                            get_d   = 1'b1;
                            state_d = REQ;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
